microwave_cook_controller: RTL and testbench

Sequencing controller for the microwave cook cycle. It owns the 3-bit non-recycling elapsed-time counter (counts 0→7, saturates, never wraps), and derives its count enable from a clock prescaler. It sequences the cycle through idle, cooking, door-pause and done/beep phases from front-panel start/stop, the door interlock and a 3-bit cook-time select. It sits between the panel/door inputs and the magnetron, lamp and beeper drivers.

---
 rtl/microwave_cook_controller.sv | 130 +++++++++++++
 tb/tb_microwave_cook_controller.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_cook_controller.sv
// Microwave cook-cycle sequencer: prescaled tick generation, saturating elapsed-time
// counter, and IDLE/COOK/PAUSE/DONE control of magnetron, lamp and beeper.
module microwave_cook_controller #(
    parameter int TICK_DIV        = 100_000_000,
    parameter int DONE_BEEP_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       door_open,
    input  logic [2:0] time_sel,
    output logic       magnetron_en,
    output logic       light_on,
    output logic       beep,
    output logic [1:0] state,
    output logic [2:0] elapsed,
    output logic [2:0] remaining
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = $clog2(DONE_BEEP_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(DONE_BEEP_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      target_q, target_d;
    logic [2:0]      elapsed_q, elapsed_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [BW-1:0]   beep_q, beep_d;
    logic            tick;
    logic [2:0]      elapsed_inc;

    assign tick        = ((state_q == COOK) || (state_q == DONE)) && (pre_q == PRE_LAST);
    // Saturating increment: the counter must never recycle to zero.
    assign elapsed_inc = (elapsed_q == 3'd7) ? 3'd7 : elapsed_q + 3'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            target_q  <= '0;
            elapsed_q <= '0;
            pre_q     <= '0;
            beep_q    <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            elapsed_q <= elapsed_d;
            pre_q     <= pre_d;
            beep_q    <= beep_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        elapsed_d = elapsed_q;
        pre_d     = pre_q;
        beep_d    = beep_q;

        // stop outranks everything; returning to IDLE scrubs all counters.
        if (stop) begin
            state_d   = IDLE;
            target_d  = '0;
            elapsed_d = '0;
            pre_d     = '0;
            beep_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !door_open && (time_sel != 3'd0)) begin
                        state_d   = COOK;
                        target_d  = time_sel;
                        elapsed_d = '0;
                        pre_d     = '0;
                    end
                end
                COOK: begin
                    pre_d = tick ? '0 : pre_q + 1'b1;
                    if (tick) begin
                        elapsed_d = elapsed_inc;
                    end
                    if (tick && (elapsed_inc == target_q)) begin
                        state_d = DONE;
                        beep_d  = '0;
                    end else if (door_open) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (start && !door_open) begin
                        state_d = COOK;
                    end
                end
                DONE: begin
                    pre_d = tick ? '0 : pre_q + 1'b1;
                    if (tick) begin
                        if (beep_q == BEEP_LAST) begin
                            state_d   = IDLE;
                            target_d  = '0;
                            elapsed_d = '0;
                            pre_d     = '0;
                            beep_d    = '0;
                        end else begin
                            beep_d = beep_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        magnetron_en = (state_q == COOK);
        light_on     = (state_q == COOK) || (state_q == PAUSE);
        beep         = (state_q == DONE);
        state        = state_q;
        elapsed      = elapsed_q;
        remaining    = target_q - elapsed_q;
    end

endmodule

// File: tb/tb_microwave_cook_controller.sv
// Directed bench for microwave_cook_controller with TICK_DIV=4, DONE_BEEP_TICKS=2;
// each scenario task compares a packed view of all outputs against hand-derived values.
module tb_microwave_cook_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       door_open;
    logic [2:0] time_sel;
    logic       magnetron_en;
    logic       light_on;
    logic       beep;
    logic [1:0] state;
    logic [2:0] elapsed;
    logic [2:0] remaining;
    logic [10:0] obs;
    logic [10:0] exp;

    int checks;
    int failures;

    microwave_cook_controller #(
        .TICK_DIV(4),
        .DONE_BEEP_TICKS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .door_open(door_open),
        .time_sel(time_sel),
        .magnetron_en(magnetron_en),
        .light_on(light_on),
        .beep(beep),
        .state(state),
        .elapsed(elapsed),
        .remaining(remaining)
    );

    // obs = {state, elapsed, remaining, magnetron_en, light_on, beep}
    assign obs = {state, elapsed, remaining, magnetron_en, light_on, beep};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start     = 1'($urandom);
            stop      = 1'($urandom);
            door_open = 1'($urandom);
            time_sel  = 3'($urandom);
            #7;
            checks++;
            if (obs !== 11'b0) begin
                failures++;
                $display("[TB] FAIL reset_hold[%0d]: got %b expected %b", i, obs, 11'b0);
            end
        end
        start = 1'b0; stop = 1'b0; door_open = 1'b0; time_sel = 3'd0;
        #3 rst = 1'b1;
        step();
        checks++;
        if (obs !== 11'b0) begin
            failures++;
            $display("[TB] FAIL reset_release: got %b expected %b", obs, 11'b0);
        end
        time_sel = 3'd3;
        pulse_start();
        step();
        step();
        exp = {2'd1, 3'd0, 3'd3, 3'b110};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL reset_precook: got %b expected %b", obs, exp);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (magnetron_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_async_mag: got %b expected 0", magnetron_en);
        end
        checks++;
        if (obs !== 11'b0) begin
            failures++;
            $display("[TB] FAIL reset_async_all: got %b expected %b", obs, 11'b0);
        end
        #2 rst = 1'b1;
        step();
        checks++;
        if (obs !== 11'b0) begin
            failures++;
            $display("[TB] FAIL reset_resume_idle: got %b expected %b", obs, 11'b0);
        end
    endtask

    task automatic test_normal_cycle();
        time_sel = 3'd3;
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            exp = {2'd1, 3'(i / 4), 3'(3 - i / 4), 3'b110};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL normal_cook[%0d]: got %b expected %b", i, obs, exp);
            end
            step();
        end
        for (int i = 0; i < 8; i++) begin
            exp = {2'd3, 3'd3, 3'd0, 3'b001};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL normal_done[%0d]: got %b expected %b", i, obs, exp);
            end
            step();
        end
        checks++;
        if (obs !== 11'b0) begin
            failures++;
            $display("[TB] FAIL normal_back_idle: got %b expected %b", obs, 11'b0);
        end
    endtask

    task automatic test_door_pause();
        int cook_cycles;
        cook_cycles = 0;
        time_sel = 3'd2;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            if (magnetron_en === 1'b1) cook_cycles++;
            step();
        end
        if (magnetron_en === 1'b1) cook_cycles++;
        door_open = 1'b1;
        step();
        exp = {2'd2, 3'd1, 3'd1, 3'b010};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL door_pause_entry: got %b expected %b", obs, exp);
        end
        step();
        pulse_start();
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL door_pause_start_open: got %b expected %b", obs, exp);
        end
        door_open = 1'b0;
        step();
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            exp = {2'd1, 3'd1, 3'd1, 3'b110};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL door_resume[%0d]: got %b expected %b", i, obs, exp);
            end
            if (magnetron_en === 1'b1) cook_cycles++;
            step();
        end
        exp = {2'd3, 3'd2, 3'd0, 3'b001};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL door_done: got %b expected %b", obs, exp);
        end
        checks++;
        if (cook_cycles !== 8) begin
            failures++;
            $display("[TB] FAIL door_total_cook: got %0d expected 8", cook_cycles);
        end
        pulse_stop();
    endtask

    task automatic test_rejected_starts();
        door_open = 1'b1;
        time_sel  = 3'd5;
        pulse_start();
        checks++;
        if (obs !== 11'b0) begin
            failures++;
            $display("[TB] FAIL reject_door_open: got %b expected %b", obs, 11'b0);
        end
        door_open = 1'b0;
        time_sel  = 3'd0;
        pulse_start();
        checks++;
        if (obs !== 11'b0) begin
            failures++;
            $display("[TB] FAIL reject_zero_time: got %b expected %b", obs, 11'b0);
        end
        time_sel = 3'd1;
        pulse_start();
        repeat (4) step();
        exp = {2'd3, 3'd1, 3'd0, 3'b001};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL reject_enter_done: got %b expected %b", obs, exp);
        end
        time_sel  = 3'd6;
        door_open = 1'b1;
        pulse_start();
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL reject_start_in_done: got %b expected %b", obs, exp);
        end
        door_open = 1'b0;
        repeat (6) step();
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL reject_done_last: got %b expected %b", obs, exp);
        end
        step();
        checks++;
        if (obs !== 11'b0) begin
            failures++;
            $display("[TB] FAIL reject_done_to_idle: got %b expected %b", obs, 11'b0);
        end
    endtask

    task automatic test_saturation();
        time_sel = 3'd7;
        pulse_start();
        for (int i = 0; i < 28; i++) begin
            exp = {2'd1, 3'(i / 4), 3'(7 - i / 4), 3'b110};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL sat_cook[%0d]: got %b expected %b", i, obs, exp);
            end
            step();
        end
        // The DONE ticks land while elapsed is already 7; it must stay there.
        for (int i = 0; i < 8; i++) begin
            exp = {2'd3, 3'd7, 3'd0, 3'b001};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL sat_done[%0d]: got %b expected %b", i, obs, exp);
            end
            step();
        end
        checks++;
        if (obs !== 11'b0) begin
            failures++;
            $display("[TB] FAIL sat_idle: got %b expected %b", obs, 11'b0);
        end
    endtask

    task automatic test_priority();
        time_sel = 3'd3;
        pulse_start();
        step();
        door_open = 1'b1;
        step();
        exp = {2'd2, 3'd0, 3'd3, 3'b010};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL prio_pause: got %b expected %b", obs, exp);
        end
        door_open = 1'b0;
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (obs !== 11'b0) begin
            failures++;
            $display("[TB] FAIL prio_stop_over_start: got %b expected %b", obs, 11'b0);
        end
        time_sel = 3'd1;
        pulse_start();
        repeat (3) step();
        door_open = 1'b1;
        step();
        exp = {2'd3, 3'd1, 3'd0, 3'b001};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL prio_terminal_over_door: got %b expected %b", obs, exp);
        end
        step();
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL prio_door_in_done: got %b expected %b", obs, exp);
        end
        door_open = 1'b0;
        pulse_stop();
        checks++;
        if (obs !== 11'b0) begin
            failures++;
            $display("[TB] FAIL prio_stop_in_done: got %b expected %b", obs, 11'b0);
        end
        time_sel = 3'd4;
        pulse_start();
        step();
        pulse_stop();
        checks++;
        if (obs !== 11'b0) begin
            failures++;
            $display("[TB] FAIL prio_stop_in_cook: got %b expected %b", obs, 11'b0);
        end
    endtask

    task automatic test_back_to_back();
        time_sel = 3'd2;
        pulse_start();
        exp = {2'd1, 3'd0, 3'd2, 3'b110};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL b2b_first: got %b expected %b", obs, exp);
        end
        pulse_stop();
        time_sel = 3'd5;
        pulse_start();
        exp = {2'd1, 3'd0, 3'd5, 3'b110};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL b2b_second: got %b expected %b", obs, exp);
        end
        repeat (4) step();
        exp = {2'd1, 3'd1, 3'd4, 3'b110};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL b2b_second_tick: got %b expected %b", obs, exp);
        end
        pulse_stop();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        door_open = 1'b0;
        time_sel  = 3'd0;
        test_reset();
        test_normal_cycle();
        test_door_pause();
        test_rejected_starts();
        test_saturation();
        test_priority();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
